// File: rtl/exc_pkg.sv
// Shared types and constants for the precise-exception controller.
// The request struct is sized by EXC_XLEN/EXC_CAUSE_W, which are also the top's default widths.
package exc_pkg;

    localparam int EXC_XLEN    = 32;
    localparam int EXC_CAUSE_W = 4;

    localparam logic [EXC_CAUSE_W-1:0] CAUSE_ILLEGAL          = 4'd2;
    localparam logic [EXC_CAUSE_W-1:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
    localparam logic [EXC_CAUSE_W-1:0] CAUSE_MISALIGNED_STORE = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_HANDLER  = 3'd3,
        ST_RETURN   = 3'd4,
        ST_FATAL    = 3'd5
    } exc_state_e;

    typedef struct packed {
        logic                   valid;
        logic [EXC_XLEN-1:0]    pc;
        logic [EXC_CAUSE_W-1:0] cause;
        logic [EXC_XLEN-1:0]    tval;
    } exc_req_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exc_prio_sel.sv
// Oldest-stage picker: the highest-index valid request wins; the flush mask
// covers the winner and every younger (lower-index) stage.
module exc_prio_sel
    import exc_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_valid,
    output logic [IDX_W-1:0]   o_idx,
    output logic [NUM_SRC-1:0] o_onehot,
    output logic [NUM_SRC-1:0] o_mask
);

    logic w_any;

    assign w_any = |i_valid;

    always_comb begin
        o_idx    = '0;
        o_onehot = '0;
        o_mask   = '0;
        // Ascending scan: the last hit is the oldest stage.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_valid[i]) begin
                o_idx       = IDX_W'(i);
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            o_mask[k] = w_any && (k <= int'(o_idx));
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Precise-exception controller: flushes from the oldest faulting stage down,
// drains memory, vectors to the handler, and returns to EPC+4 on iret.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int              NUM_SRC    = 4,
    parameter int              XLEN       = EXC_XLEN,
    parameter int              CAUSE_W    = EXC_CAUSE_W,
    parameter logic [XLEN-1:0] HANDLER_PC = XLEN'('h0000_2000),
    parameter int              CNT_W      = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_SRC-1:0]               i_exc_valid,
    input  logic [NUM_SRC-1:0][XLEN-1:0]     i_exc_pc,
    input  logic [NUM_SRC-1:0][CAUSE_W-1:0]  i_exc_cause,
    input  logic [NUM_SRC-1:0][XLEN-1:0]     i_exc_tval,
    input  logic                             i_mem_busy,
    input  logic                             i_iret,
    output logic [NUM_SRC-1:0]               o_flush,
    output logic                             o_stall_fetch,
    output logic                             o_redirect_valid,
    output logic [XLEN-1:0]                  o_redirect_pc,
    output logic [XLEN-1:0]                  o_epc,
    output logic [XLEN-1:0]                  o_tval,
    output logic [CAUSE_W-1:0]               o_cause,
    output logic                             o_in_handler,
    output logic                             o_fatal,
    output logic [CNT_W-1:0]                 o_exc_count
);

    localparam int IDX_W = idx_width(NUM_SRC);

    exc_state_e        r_state;
    logic [XLEN-1:0]   r_epc;
    logic [XLEN-1:0]   r_tval;
    logic [CAUSE_W-1:0] r_cause;
    logic [CNT_W-1:0]  r_exc_count;
    logic              r_stall_fetch;
    logic              r_redirect_valid;
    logic [XLEN-1:0]   r_redirect_pc;
    logic              r_in_handler;
    logic              r_fatal;
    logic              r_flush_all;

    logic [IDX_W-1:0]   w_idx;
    logic [NUM_SRC-1:0] w_onehot;
    logic [NUM_SRC-1:0] w_mask;
    exc_req_t           w_req [NUM_SRC];
    exc_req_t           w_win;
    logic               w_take;

    exc_prio_sel #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio_sel (
        .i_valid  (i_exc_valid),
        .o_idx    (w_idx),
        .o_onehot (w_onehot),
        .o_mask   (w_mask)
    );

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_req[i].valid = i_exc_valid[i];
            w_req[i].pc    = EXC_XLEN'(i_exc_pc[i]);
            w_req[i].cause = EXC_CAUSE_W'(i_exc_cause[i]);
            w_req[i].tval  = EXC_XLEN'(i_exc_tval[i]);
        end
        w_win = w_req[w_idx];
    end

    assign w_take = (|w_onehot) && w_win.valid;

    // Only IDLE exposes the partial mask; every other flushing state kills all stages.
    assign o_flush = !i_rst_n              ? '0 :
                     (r_state == ST_IDLE)  ? w_mask :
                                             {NUM_SRC{r_flush_all}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_epc            <= '0;
            r_tval           <= '0;
            r_cause          <= '0;
            r_exc_count      <= '0;
            r_stall_fetch    <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_in_handler     <= 1'b0;
            r_fatal          <= 1'b0;
            r_flush_all      <= 1'b0;
        end else begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_epc         <= XLEN'(w_win.pc);
                        r_cause       <= CAUSE_W'(w_win.cause);
                        r_tval        <= XLEN'(w_win.tval);
                        if (r_exc_count != {CNT_W{1'b1}}) begin
                            r_exc_count <= r_exc_count + CNT_W'(1);
                        end
                        r_stall_fetch <= 1'b1;
                        r_flush_all   <= 1'b1;
                        r_state       <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!i_mem_busy) begin
                        r_stall_fetch    <= 1'b0;
                        r_flush_all      <= 1'b0;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= HANDLER_PC;
                        r_state          <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    r_in_handler <= 1'b1;
                    r_state      <= ST_HANDLER;
                end
                ST_HANDLER: begin
                    // A fault inside the handler is a double fault, even alongside iret.
                    if (|i_exc_valid) begin
                        r_in_handler  <= 1'b0;
                        r_stall_fetch <= 1'b1;
                        r_flush_all   <= 1'b1;
                        r_fatal       <= 1'b1;
                        r_state       <= ST_FATAL;
                    end else if (i_iret) begin
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_epc + XLEN'(4);
                        r_flush_all      <= 1'b1;
                        r_state          <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    r_in_handler <= 1'b0;
                    r_flush_all  <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                ST_FATAL: begin
                    r_state <= ST_FATAL;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_stall_fetch    = r_stall_fetch;
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_epc            = r_epc;
    assign o_tval           = r_tval;
    assign o_cause          = r_cause;
    assign o_in_handler     = r_in_handler;
    assign o_fatal          = r_fatal;
    assign o_exc_count      = r_exc_count;

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Parametrised precise-exception controller for the RISCVCPU pipeline. It takes per-stage exception requests (e.g. misaligned store raised in MEM), selects the oldest, and flushes that stage and all younger ones. It waits for in-flight memory traffic to drain, then redirects fetch to a fixed handler, holds EPC/cause/tval, and supports return-from-handler. Nested exceptions latch a fatal halt. It sits beside the hazard unit, driving the stage flush lines and the PC-redirect mux in the IF stage.

## Interface
- NUM_SRC, 4, number of pipeline stages that can raise exceptions; index 0 = youngest (IF), NUM_SRC-1 = oldest (MEM)
- XLEN, 32, PC/address width
- CAUSE_W, 4, cause code width
- HANDLER_PC, 32'h0000_2000, trap vector (XLEN bits)
- CNT_W, 16, exception counter width

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- exc_valid  in  NUM_SRC  per-stage exception request
- exc_pc  in  NUM_SRC x XLEN  PC of faulting instruction per stage
- exc_cause  in  NUM_SRC x CAUSE_W  cause per stage
- exc_tval  in  NUM_SRC x XLEN  faulting address/value per stage
- mem_busy  in  1  cache/main-memory transaction (incl. drain) in progress
- iret  in  1  return-from-handler instruction reached commit
- flush  out  NUM_SRC  kill instruction in stage i this cycle
- stall_fetch  out  1  hold PC and IF/ID
- redirect_valid  out  1  one-cycle PC load strobe
- redirect_pc  out  XLEN  PC to load
- epc, tval  out  XLEN  saved PC / faulting value
- cause  out  CAUSE_W  saved cause
- in_handler  out  1  handler executing
- fatal  out  1  sticky double fault
- exc_count  out  CNT_W  accepted exceptions, saturating

## Operation
- States: IDLE, DRAIN, REDIRECT, HANDLER, RETURN, FATAL.
- IDLE: winner = highest index with exc_valid set. On any valid:
  - flush[k]=1 for all k ≤ winner, combinationally in the same cycle.
  - epc/cause/tval capture the winner's values at the edge; exc_count increments (holds at all-ones).
  - Next state is DRAIN.
- DRAIN: stall_fetch=1, flush all stages. Stay while mem_busy=1; go to REDIRECT when mem_busy=0.
- REDIRECT: redirect_valid=1, redirect_pc=HANDLER_PC, stall_fetch=0; next HANDLER.
- HANDLER: in_handler=1; exc_valid is ignored for capture.
  - Any exc_valid → FATAL. This applies even when it coincides with iret.
  - iret alone → RETURN.
- RETURN: redirect_valid=1, redirect_pc=epc+4 (mod 2^XLEN), flush all stages; next IDLE, with in_handler cleared.
- FATAL: stall_fetch=1, flush all, fatal=1; exit only by reset.
- Reset values:
  - Registers: state IDLE; epc, cause, tval, exc_count = 0.
  - Outputs: all strobes 0, in_handler=0, fatal=0, redirect_pc=0.
- Any exception input is ignored outside IDLE/HANDLER.

## Timing
- Exception seen in IDLE at cycle T:
  - flush asserts at T.
  - epc/cause/tval/exc_count are valid from T+1.
  - DRAIN starts at T+1.
- If mem_busy=0 at T+1, redirect_valid pulses at T+2. Each extra busy cycle delays the pulse by one cycle.
- in_handler rises at T+3 when there is no drain delay.
- iret sampled in HANDLER at cycle R gives a redirect_valid pulse at R+1; in_handler falls at R+2.
- Reset asserted in any state returns all outputs to their reset values immediately (async); a pending redirect is dropped.

## Structure
- Shared package exc_pkg holds:
  - the state enum;
  - cause constants CAUSE_ILLEGAL=2, CAUSE_MISALIGNED_LOAD=4, CAUSE_MISALIGNED_STORE=6;
  - the per-source request struct {valid, pc, cause, tval}.
- One sub-module, exc_prio_sel: combinational highest-index-wins picker over NUM_SRC. It outputs the winner index, the one-hot winner and the flush mask.

## Test plan
- MEM (src 3) misaligned store, pc=0x8, cause=6, tval=0x1, mem_busy=0 → flush=4'b1111 at T; epc=8, cause=6, tval=1; redirect_valid with 0x2000 at T+2; exc_count=1.
- ID and MEM valid in the same cycle (pc 0xC, 0x8) → MEM wins: epc=0x8, flush=4'b1111. EX alone (pc 0x10) → flush=4'b0111.
- mem_busy held for 3 cycles after the exception → redirect_valid at T+5, stall_fetch high T+1..T+4.
- iret in HANDLER with epc=0x8 → redirect_pc=0xC the next cycle, flush all, then IDLE. Also check epc=0xFFFF_FFFC → redirect_pc=0x0.
- exc_valid arriving together with iret in HANDLER → fatal=1, stall_fetch=1 held 20 cycles, no redirect; reset clears it.
- CNT_W=2: six exception/iret rounds → exc_count saturates at 3. Reset asserted mid-DRAIN → IDLE, outputs zero, no redirect pulse.
